// File: rtl/mul_accumulator.sv
// Saturating multiply-accumulate back end: sums COUNT unsigned products per result
// and hands the finished sum plus an overflow flag out on a valid/ready port.
module mul_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  out_sum_q, out_sum_d;
    logic              out_ovf_q, out_ovf_d;

    logic              accept;
    logic [ACC_W:0]    sum_wide;
    logic [ACC_W-1:0]  acc_new;
    logic              ovf_new;

    // in_ready depends only on registered state and clr, never on out_ready
    assign in_ready  = (state_q == ACCUM) && !clr;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACCUM) && (cnt_q != '0);
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign accept    = in_valid && in_ready;

    // Once acc is all ones any nonzero product overflows again, so saturation sticks
    assign sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign acc_new  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign ovf_new  = ovf_q | sum_wide[ACC_W];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;

        if (clr) begin
            state_d   = ACCUM;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            out_sum_d = '0;
            out_ovf_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (cnt_q == CNT_LAST) begin
                            out_sum_d = acc_new;
                            out_ovf_d = ovf_new;
                            state_d   = DONE;
                            acc_d     = '0;
                            cnt_d     = '0;
                            ovf_d     = 1'b0;
                        end else begin
                            acc_d = acc_new;
                            ovf_d = ovf_new;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: default, narrow-accumulator (ACC_W=9) and
// COUNT=1 instances, each checked against hand-computed sums.
module tb_mul_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // default instance
    logic        d_clr = 0, d_in_valid = 0, d_out_ready = 1;
    logic [7:0]  d_in_prod = 0;
    logic        d_in_ready, d_out_valid, d_out_ovf, d_busy;
    logic [11:0] d_out_sum;

    // ACC_W = 9 instance
    logic        s_clr = 0, s_in_valid = 0, s_out_ready = 1;
    logic [7:0]  s_in_prod = 0;
    logic        s_in_ready, s_out_valid, s_out_ovf, s_busy;
    logic [8:0]  s_out_sum;

    // COUNT = 1 instance
    logic        o_clr = 0, o_in_valid = 0, o_out_ready = 1;
    logic [7:0]  o_in_prod = 0;
    logic        o_in_ready, o_out_valid, o_out_ovf, o_busy;
    logic [11:0] o_out_sum;

    mul_accumulator u_def (
        .clk(clk), .rst(rst), .clr(d_clr),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_prod(d_in_prod),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_sum(d_out_sum), .out_ovf(d_out_ovf), .busy(d_busy)
    );

    mul_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT(4)) u_sat (
        .clk(clk), .rst(rst), .clr(s_clr),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_prod(s_in_prod),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_ovf(s_out_ovf), .busy(s_busy)
    );

    mul_accumulator #(.PROD_W(8), .ACC_W(12), .COUNT(1)) u_one (
        .clk(clk), .rst(rst), .clr(o_clr),
        .in_valid(o_in_valid), .in_ready(o_in_ready), .in_prod(o_in_prod),
        .out_valid(o_out_valid), .out_ready(o_out_ready),
        .out_sum(o_out_sum), .out_ovf(o_out_ovf), .busy(o_busy)
    );

    // advance one clock; outputs are read 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++; if (d_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", d_out_valid); end
        checks++; if (d_out_sum !== 12'd0) begin failures++; $display("FAIL reset_out_sum got=%0d exp=0", d_out_sum); end
        checks++; if (d_busy !== 1'b0 || d_out_ovf !== 1'b0) begin failures++; $display("FAIL reset_busy_ovf got=%0b%0b exp=00", d_busy, d_out_ovf); end
        #10 rst = 1'b0;
        step();
        checks++; if (d_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", d_in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        d_out_ready = 1'b1;
        d_in_valid  = 1'b1;
        d_in_prod   = 8'd225;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) begin
                checks++; if (d_out_valid !== 1'b0 || d_busy !== 1'b1) begin failures++; $display("FAIL b2b_early_%0d valid/busy got=%0b%0b exp=01", i, d_out_valid, d_busy); end
            end
        end
        d_in_valid = 1'b0;
        checks++; if (d_out_valid !== 1'b1) begin failures++; $display("FAIL b2b_out_valid got=%0b exp=1", d_out_valid); end
        checks++; if (d_out_sum !== 12'd900 || d_out_ovf !== 1'b0) begin failures++; $display("FAIL b2b_sum got=%0d ovf=%0b exp=900 ovf=0", d_out_sum, d_out_ovf); end
        checks++; if (d_in_ready !== 1'b0 || d_busy !== 1'b0) begin failures++; $display("FAIL b2b_done_ready_busy got=%0b%0b exp=00", d_in_ready, d_busy); end
        step();
        checks++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_release valid/ready got=%0b%0b exp=01", d_out_valid, d_in_ready); end
        $display("test_back_to_back sum=%0d", d_out_sum);
    endtask

    task automatic test_gaps_stall();
        logic [7:0] prods [4];
        prods[0] = 8'd3; prods[1] = 8'd5; prods[2] = 8'd7; prods[3] = 8'd9;
        d_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < i; g++) step();
            d_in_valid = 1'b1;
            d_in_prod  = prods[i];
            step();
            d_in_valid = 1'b0;
        end
        checks++; if (d_out_valid !== 1'b1 || d_out_sum !== 12'd24) begin failures++; $display("FAIL gaps_sum valid=%0b got=%0d exp=24", d_out_valid, d_out_sum); end
        // offer a product during the stall; it must be refused
        d_in_valid = 1'b1;
        d_in_prod  = 8'd99;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (d_out_valid !== 1'b1 || d_out_sum !== 12'd24 || d_in_ready !== 1'b0) begin failures++; $display("FAIL stall_%0d valid=%0b sum=%0d ready=%0b exp 1/24/0", k, d_out_valid, d_out_sum, d_in_ready); end
        end
        d_out_ready = 1'b1;
        step();
        d_in_valid = 1'b0;
        checks++; if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin failures++; $display("FAIL stall_release ready/valid got=%0b%0b exp=10", d_in_ready, d_out_valid); end
        checks++; if (d_busy !== 1'b0) begin failures++; $display("FAIL stall_no_accept busy got=%0b exp=0", d_busy); end
        $display("test_gaps_stall sum=24");
    endtask

    task automatic test_saturation();
        logic [7:0] prods [8];
        prods[0] = 8'd225; prods[1] = 8'd225; prods[2] = 8'd225; prods[3] = 8'd10;
        prods[4] = 8'd1;   prods[5] = 8'd1;   prods[6] = 8'd1;   prods[7] = 8'd1;
        s_out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                s_in_valid = 1'b1;
                s_in_prod  = prods[r*4 + i];
                step();
            end
            s_in_valid = 1'b0;
            if (r == 0) begin
                checks++; if (s_out_valid !== 1'b1 || s_out_sum !== 9'd511 || s_out_ovf !== 1'b1) begin failures++; $display("FAIL sat_result valid=%0b sum=%0d ovf=%0b exp 1/511/1", s_out_valid, s_out_sum, s_out_ovf); end
            end else begin
                checks++; if (s_out_valid !== 1'b1 || s_out_sum !== 9'd4 || s_out_ovf !== 1'b0) begin failures++; $display("FAIL sat_next_result valid=%0b sum=%0d ovf=%0b exp 1/4/0", s_out_valid, s_out_sum, s_out_ovf); end
            end
            step();
        end
        $display("test_saturation done");
    endtask

    task automatic test_clr();
        d_out_ready = 1'b1;
        d_in_valid  = 1'b1;
        d_in_prod   = 8'd100;
        step();
        step();
        d_clr     = 1'b1;
        d_in_prod = 8'd50;
        #1;
        checks++; if (d_in_ready !== 1'b0) begin failures++; $display("FAIL clr_in_ready got=%0b exp=0", d_in_ready); end
        step();
        d_clr = 1'b0;
        checks++; if (d_busy !== 1'b0 || d_out_sum !== 12'd0) begin failures++; $display("FAIL clr_cleared busy=%0b sum=%0d exp 0/0", d_busy, d_out_sum); end
        for (int i = 1; i <= 4; i++) begin
            d_in_prod = 8'(i);
            step();
            if (i == 1) begin
                checks++; if (d_busy !== 1'b1) begin failures++; $display("FAIL clr_busy_after_first got=%0b exp=1", d_busy); end
            end
        end
        d_in_valid = 1'b0;
        checks++; if (d_out_valid !== 1'b1 || d_out_sum !== 12'd10 || d_out_ovf !== 1'b0) begin failures++; $display("FAIL clr_result valid=%0b sum=%0d ovf=%0b exp 1/10/0", d_out_valid, d_out_sum, d_out_ovf); end
        step();
        $display("test_clr sum=10");
    endtask

    task automatic test_async_reset();
        d_out_ready = 1'b0;
        d_in_valid  = 1'b1;
        d_in_prod   = 8'd7;
        step();
        step();
        d_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (d_busy !== 1'b0 || d_out_valid !== 1'b0) begin failures++; $display("FAIL arst_mid busy/valid got=%0b%0b exp=00", d_busy, d_out_valid); end
        #1 rst = 1'b0;
        step();
        checks++; if (d_in_ready !== 1'b1) begin failures++; $display("FAIL arst_mid_ready got=%0b exp=1", d_in_ready); end
        d_in_valid = 1'b1;
        d_in_prod  = 8'd1;
        for (int i = 0; i < 4; i++) step();
        d_in_valid = 1'b0;
        checks++; if (d_out_valid !== 1'b1 || d_out_sum !== 12'd4) begin failures++; $display("FAIL arst_clean_result valid=%0b sum=%0d exp 1/4", d_out_valid, d_out_sum); end
        #2 rst = 1'b1;
        #1;
        checks++; if (d_out_valid !== 1'b0 || d_out_sum !== 12'd0 || d_out_ovf !== 1'b0) begin failures++; $display("FAIL arst_done valid=%0b sum=%0d ovf=%0b exp 0/0/0", d_out_valid, d_out_sum, d_out_ovf); end
        #1 rst = 1'b0;
        step();
        checks++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin failures++; $display("FAIL arst_done_release valid/ready got=%0b%0b exp=01", d_out_valid, d_in_ready); end
        d_out_ready = 1'b1;
        d_in_valid  = 1'b1;
        d_in_prod   = 8'd2;
        for (int i = 0; i < 4; i++) step();
        d_in_valid = 1'b0;
        checks++; if (d_out_sum !== 12'd8) begin failures++; $display("FAIL arst_after_result got=%0d exp=8", d_out_sum); end
        step();
        $display("test_async_reset done");
    endtask

    task automatic test_count_one();
        o_out_ready = 1'b1;
        o_in_valid  = 1'b1;
        o_in_prod   = 8'd0;
        step();
        o_in_prod = 8'd225;
        checks++; if (o_out_valid !== 1'b1 || o_out_sum !== 12'd0 || o_busy !== 1'b0) begin failures++; $display("FAIL c1_first valid=%0b sum=%0d busy=%0b exp 1/0/0", o_out_valid, o_out_sum, o_busy); end
        step();
        checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL c1_gap valid got=%0b exp=0", o_out_valid); end
        step();
        o_in_valid = 1'b0;
        checks++; if (o_out_valid !== 1'b1 || o_out_sum !== 12'd225) begin failures++; $display("FAIL c1_second valid=%0b sum=%0d exp 1/225", o_out_valid, o_out_sum); end
        step();
        $display("test_count_one done");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps_stall();
        test_saturation();
        test_clr();
        test_async_reset();
        test_count_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
